// File: rtl/stopwatch_pkg.sv
// Shared types for the lap stopwatch: FSM states, BCD digit type and a
// single-digit increment helper used by both the digit cells and the top.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_step(input bcd_t d, input logic inc);
    if (!inc) return d;
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch count; carry_out is combinational so a full
// carry ripple through every digit settles within one clock.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  bcd_t digit_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_reg <= '0;
    end else if (clr) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= bcd_step(digit_reg, inc_in);
    end
  end

  assign digit     = digit_reg;
  assign carry_out = inc_in && (digit_reg == BCD_MAX);

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with prescaler, run/pause/clear control, lap freeze of the
// display and a sticky overflow flag on wrap from all-9s.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   display,
  output logic                  running,
  output logic                  lap_active,
  output logic                  tick,
  output logic                  overflow
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t              state_reg, state_next;
  logic [PW-1:0]       presc_reg;
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] count, count_next, lap_reg, display_reg, display_next;
  logic                lap_active_reg, lap_active_next, lap_prev_reg;
  logic                tick_reg, overflow_reg;
  logic                presc_wrap, lap_rise, snap;

  // Pause outranks start, clear outranks both.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else if (pause) begin
      if (state_reg == RUN) state_next = PAUSED;
    end else if (start) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  assign presc_wrap = (state_reg == RUN) && (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
    end else if (clear) begin
      presc_reg <= '0;
    end else if (state_reg == RUN) begin
      presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
    end
  end

  assign carry[0] = presc_wrap && !clear;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clear),
        .inc_in    (carry[gi]),
        .digit     (count[4*gi +: 4]),
        .carry_out (carry[gi+1])
      );
      // Mirror of the digit's next value so the display register can load it
      // in the same cycle the count changes.
      assign count_next[4*gi +: 4] = clear ? 4'd0 : bcd_step(count[4*gi +: 4], carry[gi]);
    end
  endgenerate

  assign lap_rise = lap && !lap_prev_reg;

  always_comb begin
    lap_active_next = lap_active_reg;
    snap            = 1'b0;
    if (clear) begin
      lap_active_next = 1'b0;
    end else if (lap_rise) begin
      if (lap_active_reg) begin
        lap_active_next = 1'b0;
      end else if (state_reg != IDLE) begin
        lap_active_next = 1'b1;
        snap            = 1'b1;
      end
    end
  end

  // A snapshot takes the pre-increment count even on a tick cycle.
  assign display_next = lap_active_next ? (snap ? count : lap_reg) : count_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_reg        <= '0;
      lap_active_reg <= 1'b0;
      lap_prev_reg   <= 1'b0;
      display_reg    <= '0;
      tick_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (snap) lap_reg <= count;
      lap_active_reg <= lap_active_next;
      lap_prev_reg   <= lap;
      display_reg    <= display_next;
      tick_reg       <= carry[0];
      if (clear)              overflow_reg <= 1'b0;
      else if (carry[DIGITS]) overflow_reg <= 1'b1;
    end
  end

  assign display    = display_reg;
  assign running    = (state_reg == RUN);
  assign lap_active = lap_active_reg;
  assign tick       = tick_reg;
  assign overflow   = overflow_reg;

endmodule
